// File: rtl/add_pkg.sv
// add_pkg: shared definitions for the pipelined adder (pipe_add).
//   calc_stages : pipeline depth (and latency) for a given width/slice split
//   smax_fn/smin_fn : signed limits 0111..1 / 1000..0 for a given width
//                     (used only when PIPE_ADD_SAT_EN is defined)
//   stage_ctl_t : per-stage valid flag plus the carry leaving that stage
package add_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int calc_stages(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic logic [63:0] smax_fn(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] smin_fn(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/add_slice.sv
// add_slice: combinational N-bit ripple of full-adder cells.
// Ports:
//   a, b  : N-bit operand slices
//   cin   : carry into bit 0
//   sum   : N-bit slice sum
//   cout  : carry out of bit N-1
module add_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end

endmodule

// File: rtl/pipe_add.sv
// pipe_add: pipelined two's-complement adder/subtractor.
// The WIDTH-bit operands are resolved SLICE bits per stage; STAGES=WIDTH/SLICE
// is both the pipeline depth and the latency. Throughput: one op per cycle.
// Optional feature macro: PIPE_ADD_SAT_EN -- saturate sum to the signed limit
// on overflow (cout/ov still report the raw result).
// Ports:
//   clk, rst          : clock (rising edge), async active-high reset
//   in_valid/in_ready : operand handshake (a, b, cin, sub)
//   sub               : 1 = a - b (cin ignored), 0 = a + b + cin
//   out_valid/out_ready : result handshake (sum, cout, ov)
//   cout              : raw carry out of the MSB (no borrow inversion)
//   ov                : signed overflow
//
// Handshake: a transfer happens on an edge where valid & ready are both 1.
// The whole pipeline advances together when adv = ~out_valid | out_ready, and
// in_ready = adv. A producer holds its inputs while in_valid=1 & in_ready=0;
// the result outputs stay stable while out_valid=1 & out_ready=0.
module pipe_add
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ov
);

  localparam int STAGES = calc_stages(WIDTH, SLICE);
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("pipe_add: WIDTH must be a multiple of SLICE");
  end

`ifdef PIPE_ADD_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax_fn(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin_fn(WIDTH));
`endif

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Per-stage inputs: stage 0 reads the conditioned ports, stage k the
  // registers of stage k-1.
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             v_src [STAGES];
  logic             c_src [STAGES];
  logic [SLICE-1:0] sl_sum  [STAGES];
  logic             sl_cout [STAGES];

  // Stage registers: operands travel with the partially resolved sum so each
  // stage only needs its own slice of them.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  stage_ctl_t       ctl_q [STAGES];
  stage_ctl_t       ctl_d [STAGES];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ov_q, ov_d;

  logic [WIDTH-1:0] fin_sum;
  logic [WIDTH-1:0] fin_res;
  logic             fin_a_msb;
  logic             fin_b_msb;
  logic             fin_ov;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_src[k] = a;
      assign b_src[k] = b_eff;
      assign s_src[k] = '0;
      assign v_src[k] = in_valid;
      assign c_src[k] = c0;
    end else begin : g_next
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign s_src[k] = s_q[k-1];
      assign v_src[k] = ctl_q[k-1].valid;
      assign c_src[k] = ctl_q[k-1].carry;
    end

    add_slice #(.N(SLICE)) u_slice (
      .a    (a_src[k][k*SLICE +: SLICE]),
      .b    (b_src[k][k*SLICE +: SLICE]),
      .cin  (c_src[k]),
      .sum  (sl_sum[k]),
      .cout (sl_cout[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      s_d[k]   = s_q[k];
      ctl_d[k] = ctl_q[k];
      if (adv) begin
        a_d[k]               = a_src[k];
        b_d[k]               = b_src[k];
        s_d[k]               = s_src[k];
        s_d[k][k*SLICE +: SLICE] = sl_sum[k];
        ctl_d[k].valid       = v_src[k];
        ctl_d[k].carry       = sl_cout[k];
      end
    end
  end

  // Flags come from the operands that rode along with the final stage.
  always_comb begin
    fin_sum   = s_q[LAST];
    fin_a_msb = a_q[LAST][WIDTH-1];
    fin_b_msb = b_q[LAST][WIDTH-1];
    fin_ov    = (fin_a_msb == fin_b_msb) & (fin_sum[WIDTH-1] != fin_a_msb);
`ifdef PIPE_ADD_SAT_EN
    // Overflow sign follows operand A: negative operands overflow downward.
    fin_res   = fin_ov ? (fin_a_msb ? SMIN : SMAX) : fin_sum;
`else
    fin_res   = fin_sum;
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ov_d        = ov_q;
    if (adv) begin
      out_valid_d = ctl_q[LAST].valid;
      if (ctl_q[LAST].valid) begin
        sum_d  = fin_res;
        cout_d = ctl_q[LAST].carry;
        ov_d   = fin_ov;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        ctl_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        ctl_q[k] <= ctl_d[k];
      end
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ov_q        <= ov_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ov        = ov_q;

endmodule

// File: doc/pipe_add.md
Name: pipe_add

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It is the successor of the team's 8-bit ripple adder.
- Operand width is split into SLICE-bit ripple segments, each registered, so the carry chain per cycle is bounded.
- Adds valid/ready flow control, subtract mode, and separate unsigned-carry and signed-overflow flags.
- Sits between operand registers and the ALU result mux, and feeds accumulators and address generators.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SLICE, otherwise elaboration fails via a generate-time error.
- SLICE, 4, bits resolved per pipeline stage; STAGES = WIDTH/SLICE is both the pipeline depth and the latency.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  pipeline can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  1 = compute a - b.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  unsigned carry-out of MSB, raw adder carry (no borrow inversion).
- ov  out  1  signed overflow.

Behaviour:
- Reset (async assert, released on clk edge): all stage valid bits, out_valid, sum, cout, ov = 0. In-flight operations are discarded; no result emerges after reset.
- Operand conditioning at input: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] of a and b_eff with the carry from stage k-1 (c0 for stage 0). It registers its partial sum together with the still-unprocessed upper operand bits and the lower sum bits already resolved.
- Latency: an operand accepted at edge N produces out_valid=1 after edge N+STAGES. Throughput is one operation per cycle.
- Flow control is a global advance: adv = ~out_valid | out_ready, and in_ready = adv.
  - When adv=0, every stage register holds, and sum/cout/ov/out_valid stay stable.
  - When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Accept condition: in_valid & in_ready. Producers must hold a/b/cin/sub stable while in_valid=1 and in_ready=0.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ov = (a[MSB]==b_eff[MSB]) & (sum[MSB]!=a[MSB]).
- Arithmetic is modulo 2^WIDTH; sum wraps and the flags report the wrap.
- When out_valid=0, sum/cout/ov may hold stale data; the bench checks them only when out_valid=1.
- Simultaneous out_ready=1 with a new input: the output is consumed and the pipeline shifts in the same edge, with no bubble inserted.
- STAGES=1 is legal: the design degenerates to a registered ripple adder with latency 1.

Optional Feature:
- PIPE_ADD_SAT_EN defined: when the final ov=1, sum is replaced by the signed limit. Positive overflow gives 0111..1; negative overflow gives 1000..0. cout and ov are still reported unmodified.
- Not defined: sum wraps modulo 2^WIDTH. The saturation logic is absent.

Decomposition:
- Shared package add_pkg holds:
  - localparam function for STAGES;
  - signed-limit constants (SMAX/SMIN helper functions of WIDTH);
  - a typedef for the per-stage carry/valid bundle.
- Natural sub-module: add_slice. It is a combinational SLICE-bit ripple of full-adder cells with cin/cout, instantiated once per stage by generate. Stage registers live in pipe_add.

Test Plan (WIDTH=16, SLICE=4, latency 4):
- a=0x00FF, b=0x0001, cin=0, sub=0 -> four cycles later sum=0x0100, cout=0, ov=0 (carry crosses slice boundaries).
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ov=1, cout=0. With PIPE_ADD_SAT_EN: sum=0x7FFF, ov=1.
- a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ov=0. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ov=1, cout=1. With PIPE_ADD_SAT_EN: sum=0x8000.
- Ten back-to-back operations with out_ready=1 -> ten results on consecutive cycles in order, out_valid continuous from cycle 4.
- out_ready=0 for 5 cycles mid-stream -> in_ready=0 and outputs stable. No operation is lost or duplicated after release.
- rst asserted for 1 cycle with 3 operations in flight -> out_valid=0 immediately, sum=0, and none of the 3 results ever appears.
